pipeline_ctrl: RTL and testbench

Backward-direction control for the five-stage pipeline: collects stall requests from IF, ID (load-use) and MEM, and branch-redirect requests from EX. It produces the per-stage stall vector, the bubble and flush strobes consumed by the if_id/id_ex/ex_mem/mem_wb registers, and the PC redirect. It keeps a registered shadow of the ID/EX load destination so it can detect load-use hazards. It also runs a small FSM that defers a redirect while an instruction fetch is still outstanding.

---
 rtl/pipeline_ctrl_pkg.sv | 36 +++
 rtl/pipeline_ctrl_load_use_tracker.sv | 54 +++++
 rtl/pipeline_ctrl.sv | 125 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// ============================================================================
// Module      : pipeline_ctrl_pkg
// Description : Shared widths, stall masks and FSM encoding for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_ctrl_pkg;

  localparam int REG_BUS      = 32;
  localparam int REG_ADDR_BUS = 5;
  localparam int STALL_BUS    = 6;

  localparam int c_stall_pc  = 0;
  localparam int c_stall_if  = 1;
  localparam int c_stall_id  = 2;
  localparam int c_stall_ex  = 3;
  localparam int c_stall_mem = 4;
  localparam int c_stall_wb  = 5;

  localparam logic [STALL_BUS-1:0] c_mask_mem = 6'b011111;
  localparam logic [STALL_BUS-1:0] c_mask_id  = 6'b000111;
  localparam logic [STALL_BUS-1:0] c_mask_if  = 6'b000011;
  localparam logic [STALL_BUS-1:0] c_no_stall = 6'b000000;

  localparam logic [REG_BUS-1:0]      c_zero_word    = '0;
  localparam logic [REG_ADDR_BUS-1:0] c_nop_reg_addr = '0;

  typedef enum logic [0:0] {
    CTRL_RUN        = 1'b0,
    CTRL_REDIR_WAIT = 1'b1
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/pipeline_ctrl_load_use_tracker.sv
// ============================================================================
// Module      : load_use_tracker
// Description : Shadows the id_ex load destination and flags load-use hazards.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module load_use_tracker
  import pipeline_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    id_valid,
  input  logic [REG_ADDR_BUS-1:0] id_rs1,
  input  logic [REG_ADDR_BUS-1:0] id_rs2,
  input  logic                    id_rs1_read,
  input  logic                    id_rs2_read,
  input  logic                    id_is_load,
  input  logic [REG_ADDR_BUS-1:0] id_wd,
  input  logic [1:0]              stall_ex_id,
  input  logic                    flush,
  output logic                    hazard
);

  logic                    r_ex_ld_v;
  logic [REG_ADDR_BUS-1:0] r_ex_ld_rd;
  logic                    w_rs1_hit;
  logic                    w_rs2_hit;

  assign w_rs1_hit = id_rs1_read && (id_rs1 == r_ex_ld_rd);
  assign w_rs2_hit = id_rs2_read && (id_rs2 == r_ex_ld_rd);
  assign hazard    = id_valid && r_ex_ld_v && (r_ex_ld_rd != c_nop_reg_addr)
                     && (w_rs1_hit || w_rs2_hit);

  // stall_ex_id[1] holds EX, stall_ex_id[0] means id_ex receives a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_ld_v  <= 1'b0;
      r_ex_ld_rd <= c_nop_reg_addr;
    end else if (flush) begin
      r_ex_ld_v  <= 1'b0;
    end else if (stall_ex_id[1]) begin
      r_ex_ld_v  <= r_ex_ld_v;
    end else if (stall_ex_id[0]) begin
      r_ex_ld_v  <= 1'b0;
    end else begin
      r_ex_ld_v  <= id_valid && id_is_load;
      r_ex_ld_rd <= id_wd;
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipeline_ctrl.sv
// ============================================================================
// Module      : pipeline_ctrl
// Description : Stall/bubble/flush generation and deferred PC redirect.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    if_stall_req,
  input  logic                    if_busy,
  input  logic                    id_valid,
  input  logic [REG_ADDR_BUS-1:0] id_rs1,
  input  logic [REG_ADDR_BUS-1:0] id_rs2,
  input  logic                    id_rs1_read,
  input  logic                    id_rs2_read,
  input  logic                    id_is_load,
  input  logic [REG_ADDR_BUS-1:0] id_wd,
  input  logic                    mem_stall_req,
  input  logic                    ex_branch_taken,
  input  logic [REG_BUS-1:0]      ex_branch_target,
  output logic [STALL_BUS-1:0]    stall,
  output logic                    bubble,
  output logic                    flush,
  output logic                    if_discard,
  output logic                    redirect_valid,
  output logic [REG_BUS-1:0]      redirect_pc
);

  ctrl_state_t          r_state;
  ctrl_state_t          w_state_nxt;
  logic [REG_BUS-1:0]   r_tgt_q;
  logic [REG_BUS-1:0]   w_tgt_nxt;
  logic                 w_hazard;
  logic                 w_hazard_eff;
  logic                 w_accept;
  logic [STALL_BUS-1:0] w_stall;
  logic                 w_bubble;
  logic                 w_discard;
  logic                 w_redir_v;
  logic [REG_BUS-1:0]   w_redir_pc;

  load_use_tracker u_tracker (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_read (id_rs1_read),
    .id_rs2_read (id_rs2_read),
    .id_is_load  (id_is_load),
    .id_wd       (id_wd),
    .stall_ex_id (w_stall[c_stall_ex:c_stall_id]),
    .flush       (w_accept),
    .hazard      (w_hazard)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= CTRL_RUN;
      r_tgt_q <= c_zero_word;
    end else begin
      r_state <= w_state_nxt;
      r_tgt_q <= w_tgt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tgt_nxt   = r_tgt_q;
    w_accept    = 1'b0;
    w_discard   = 1'b0;
    w_redir_v   = 1'b0;
    w_redir_pc  = ex_branch_target;
    case (r_state)
      CTRL_RUN: begin
        // A branch behind a MEM stall stays in EX and is re-presented later
        w_accept = ex_branch_taken && !mem_stall_req;
        if (w_accept) begin
          if (if_busy) begin
            w_tgt_nxt   = ex_branch_target;
            w_state_nxt = CTRL_REDIR_WAIT;
          end else begin
            w_redir_v   = 1'b1;
          end
        end
      end
      CTRL_REDIR_WAIT: begin
        w_discard  = 1'b1;
        w_redir_pc = r_tgt_q;
        if (!if_busy) begin
          w_redir_v   = 1'b1;
          w_state_nxt = CTRL_RUN;
        end
      end
      default: w_state_nxt = CTRL_RUN;
    endcase
  end

  assign w_hazard_eff = w_hazard && !w_accept;

  always_comb begin
    w_stall = c_no_stall;
    if (mem_stall_req) w_stall = w_stall | c_mask_mem;
    if (w_hazard_eff)  w_stall = w_stall | c_mask_id;
    if (if_stall_req)  w_stall = w_stall | c_mask_if;
    if (w_discard)     w_stall = w_stall | c_mask_if;
  end

  assign w_bubble = w_hazard_eff && !w_stall[c_stall_ex] && !w_accept;

  // Outputs are held quiet for the whole reset window, not just after the edge
  assign stall          = rst ? c_no_stall  : w_stall;
  assign bubble         = !rst && w_bubble;
  assign flush          = !rst && w_accept;
  assign if_discard     = !rst && w_discard;
  assign redirect_valid = !rst && w_redir_v;
  assign redirect_pc    = rst ? c_zero_word : w_redir_pc;

endmodule

`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed, table-driven self-checking bench for pipeline_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipeline_ctrl;

  logic        clk;
  logic        rst;
  logic        if_stall_req, if_busy, id_valid;
  logic [4:0]  id_rs1, id_rs2, id_wd;
  logic        id_rs1_read, id_rs2_read, id_is_load;
  logic        mem_stall_req, ex_branch_taken;
  logic [31:0] ex_branch_target;
  logic [5:0]  stall;
  logic        bubble, flush, if_discard, redirect_valid;
  logic [31:0] redirect_pc;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .if_stall_req     (if_stall_req),
    .if_busy          (if_busy),
    .id_valid         (id_valid),
    .id_rs1           (id_rs1),
    .id_rs2           (id_rs2),
    .id_rs1_read      (id_rs1_read),
    .id_rs2_read      (id_rs2_read),
    .id_is_load       (id_is_load),
    .id_wd            (id_wd),
    .mem_stall_req    (mem_stall_req),
    .ex_branch_taken  (ex_branch_taken),
    .ex_branch_target (ex_branch_target),
    .stall            (stall),
    .bubble           (bubble),
    .flush            (flush),
    .if_discard       (if_discard),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ifs, busy, idv;
    logic [4:0]  rs1, rs2;
    logic        r1, r2, ld;
    logic [4:0]  wd;
    logic        mem, br;
    logic [31:0] tgt;
    logic [5:0]  e_stall;
    logic        e_bub, e_fl, e_disc, e_rv, chk_pc;
    logic [31:0] e_pc;
  } vec_t;

  localparam int NV = 20;
  vec_t vecs[NV];

  function automatic vec_t mk(
    input logic ifs, busy, idv, input logic [4:0] rs1, rs2,
    input logic r1, r2, ld, input logic [4:0] wd, input logic mem, br,
    input logic [31:0] tgt, input logic [5:0] e_stall,
    input logic e_bub, e_fl, e_disc, e_rv, chk_pc, input logic [31:0] e_pc);
    vec_t v;
    v.ifs = ifs; v.busy = busy; v.idv = idv; v.rs1 = rs1; v.rs2 = rs2;
    v.r1 = r1; v.r2 = r2; v.ld = ld; v.wd = wd; v.mem = mem; v.br = br;
    v.tgt = tgt; v.e_stall = e_stall; v.e_bub = e_bub; v.e_fl = e_fl;
    v.e_disc = e_disc; v.e_rv = e_rv; v.chk_pc = chk_pc; v.e_pc = e_pc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    if_stall_req = v.ifs; if_busy = v.busy; id_valid = v.idv;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rs1_read = v.r1; id_rs2_read = v.r2;
    id_is_load = v.ld; id_wd = v.wd; mem_stall_req = v.mem;
    ex_branch_taken = v.br; ex_branch_target = v.tgt;
  endtask

  task automatic check_outs(input string tag, input vec_t v);
    chk({tag, ".stall"},  {26'd0, stall},          {26'd0, v.e_stall});
    chk({tag, ".bubble"}, {31'd0, bubble},         {31'd0, v.e_bub});
    chk({tag, ".flush"},  {31'd0, flush},          {31'd0, v.e_fl});
    chk({tag, ".discard"},{31'd0, if_discard},     {31'd0, v.e_disc});
    chk({tag, ".rv"},     {31'd0, redirect_valid}, {31'd0, v.e_rv});
    if (v.chk_pc) chk({tag, ".pc"}, redirect_pc, v.e_pc);
  endtask

  vec_t idle;
  vec_t tmp;

  initial begin
    //            ifs busy idv rs1 rs2 r1 r2 ld wd mem br tgt          stall     bub fl dis rv cpc pc
    idle     = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,      6'b000000, 0, 0, 0, 0, 0, 32'h0);
    // load x5 enters, then ID reads x5 -> one-cycle stall with bubble
    vecs[0]  = mk(0, 0, 1, 1, 2, 1, 1, 1, 5, 0, 0, 32'h0,      6'b000000, 0, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mk(0, 0, 1, 5, 2, 1, 0, 0, 6, 0, 0, 32'h0,      6'b000111, 1, 0, 0, 0, 0, 32'h0);
    vecs[2]  = mk(0, 0, 1, 5, 2, 1, 0, 0, 6, 0, 0, 32'h0,      6'b000000, 0, 0, 0, 0, 0, 32'h0);
    // load to x0 never hazards
    vecs[3]  = mk(0, 0, 1, 1, 2, 0, 0, 1, 0, 0, 0, 32'h0,      6'b000000, 0, 0, 0, 0, 0, 32'h0);
    vecs[4]  = mk(0, 0, 1, 0, 0, 1, 1, 0, 7, 0, 0, 32'h0,      6'b000000, 0, 0, 0, 0, 0, 32'h0);
    // taken branch with idle fetch port -> immediate redirect
    vecs[5]  = mk(0, 0, 1, 1, 2, 0, 0, 0, 8, 0, 1, 32'h1040,   6'b000000, 0, 1, 0, 1, 1, 32'h1040);
    // if_stall alone; the load in ID still advances into EX
    vecs[6]  = mk(1, 0, 1, 1, 2, 0, 0, 1, 5, 0, 0, 32'h0,      6'b000011, 0, 0, 0, 0, 0, 32'h0);
    // taken + load-use(rs2) + if_stall + busy -> flush wins, enter REDIR_WAIT
    vecs[7]  = mk(1, 1, 1, 1, 5, 0, 1, 0, 9, 0, 1, 32'h1040,   6'b000011, 0, 1, 0, 0, 0, 32'h0);
    // waiting: new taken branches ignored, pc shows latched target
    vecs[8]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'hdead0000, 6'b000011, 0, 0, 1, 0, 1, 32'h1040);
    vecs[9]  = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,      6'b000011, 0, 0, 1, 0, 1, 32'h1040);
    vecs[10] = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 32'h0,      6'b011111, 0, 0, 1, 0, 1, 32'h1040);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0,      6'b000011, 0, 0, 1, 1, 1, 32'h1040);
    vecs[12] = idle;
    // load x5, then MEM stall for 4 cycles with branch + load-use pending
    vecs[13] = mk(0, 0, 1, 1, 2, 0, 0, 1, 5, 0, 0, 32'h0,      6'b000000, 0, 0, 0, 0, 0, 32'h0);
    for (int i = 14; i < 18; i++)
      vecs[i] = mk(0, 0, 1, 5, 2, 1, 0, 0, 6, 1, 1, 32'h2000,  6'b011111, 0, 0, 0, 0, 0, 32'h0);
    vecs[18] = mk(0, 0, 1, 5, 2, 1, 0, 0, 6, 0, 1, 32'h2000,   6'b000000, 0, 1, 0, 1, 1, 32'h2000);
    vecs[19] = idle;

    // reset state with busy inputs: everything quiet
    rst = 1'b1;
    tmp = mk(1, 1, 1, 5, 5, 1, 1, 1, 5, 1, 1, 32'hffff_ffff, 6'b000000, 0, 0, 0, 0, 1, 32'h0);
    drive(tmp);
    repeat (2) @(negedge clk);
    check_outs("reset", tmp);
    drive(idle);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #1;
      check_outs($sformatf("vec%0d", i), vecs[i]);
    end

    // async reset while in REDIR_WAIT: outputs drop immediately, redirect lost
    @(negedge clk);
    tmp = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 32'h3000, 6'b000000, 0, 1, 0, 0, 0, 32'h0);
    drive(tmp);
    #1;
    check_outs("arst_enter", tmp);
    @(negedge clk);
    tmp = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'b000011, 0, 0, 1, 0, 1, 32'h3000);
    drive(tmp);
    #1;
    check_outs("arst_wait", tmp);
    #1;
    rst = 1'b1;
    #1;
    tmp = mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 0, 0, 0, 1, 32'h0);
    check_outs("arst_active", tmp);
    #1;
    rst = 1'b0;
    @(negedge clk);
    tmp = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 6'b000000, 0, 0, 0, 0, 0, 32'h0);
    drive(tmp);
    #1;
    check_outs("arst_after", tmp);
    @(negedge clk);
    #1;
    check_outs("arst_after2", tmp);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
